alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Sequences the 8-bit ALU for one ALU-class instruction per i_Start: classifies the opcode, drives ALU function/write controls,
//  runs memory operand fetch ((HL) or immediate) and (HL) read-modify-write write-back, then pulses o_Done.
//  Sits between the instruction decoder (i_Start/o_Busy/o_Done) and the ALU, register file and memory port.
// PARAMETERS
//  MAX_WAIT  15  enabled cycles a memory request may wait for i_Mem_Ack before abort (o_Error); 0 = wait forever
// PORTS
//  i_Clk               in   1  system clock
//  i_Reset             in   1  synchronous, active-high reset
//  i_Enable            in   1  clock enable; all state/counter updates happen only when high
//  i_Start             in   1  begin instruction; sampled only in IDLE
//  i_Opcode            in   8  opcode, captured on accepted i_Start
//  i_Prefix_CB         in   1  opcode is CB-prefixed, captured with i_Opcode
//  o_Busy              out  1  high in every state except IDLE
//  o_Done              out  1  one-cycle completion pulse
//  o_Error             out  1  one-cycle pulse: unsupported opcode or memory timeout
//  o_Opcode            out  8  captured opcode, drives ALU i_Opcode
//  o_Function_Control  out  6  ALU control: [0] main, [1] inc, [2] dec, [3] logic, [4] disable Z, [5] misc
//  o_Save_Flags        out  1  commit ALU flags this cycle
//  o_ALU_Write         out  2  ALU register write: [0] A, [1] F
//  o_Reg_Sel           out  3  register-file index (B,C,D,E,H,L,-,A = 0..7) for operand read / result write
//  o_Reg_Write         out  1  write ALU result to register o_Reg_Sel
//  o_Param_Src         out  1  ALU parameter source: 0 = register file, 1 = o_Operand
//  o_Operand           out  8  latched memory byte
//  o_Mem_Req           out  1  memory request; held until i_Mem_Ack
//  o_Mem_We            out  1  request is a write (valid with o_Mem_Req)
//  o_Mem_Addr_Sel      out  1  0 = HL, 1 = PC (PC post-increments on ack, outside this block)
//  o_Mem_Wdata         out  8  write data (latched ALU result)
//  i_Mem_Ack           in   1  completes request this cycle; read data valid same cycle
//  i_Mem_Data          in   8  memory read data
//  i_Result            in   8  ALU o_Result
// BEHAVIOUR
//  Reset: state IDLE, wait counter 0, all outputs 0. Reset wins over i_Enable and aborts any operation; no write strobe in that cycle.
//  Classes (prefix 0): 80-BF ALU A,r -> FC[0]; C6/CE/../FE ALU A,n8 -> FC[0], imm; 04/0C..3C INC r -> FC[1];
//   05/0D..3D DEC r -> FC[1]|FC[2]; 07/0F/17/1F -> FC[3]|FC[4], result to A; 27/2F/37/3F -> FC[5], result to A.
//  Prefix 1: all -> FC[3]; op[7:6]=01 (BIT) writes nothing but flags; r=op[2:0].
//  Register field: op[2:0] (ALU, CB) or op[5:3] (INC/DEC); value 6 selects (HL).
//  Main ALU writes A except CP (op[5:3]=111). Every class asserts o_Save_Flags exactly once.
//  States: IDLE, EXEC, FETCH, WRITE.
//   IDLE: i_Start -> capture opcode; register operand -> EXEC; (HL) or imm -> FETCH; unsupported -> o_Error+o_Done next cycle, IDLE.
//   FETCH: o_Mem_Req=1, We=0, Addr_Sel=(imm). On ack: o_Operand<=i_Mem_Data, -> EXEC.
//   EXEC (one cycle): FC, o_Save_Flags, A/Reg write strobes asserted; Param_Src=1 if fetched.
//    (HL) INC/DEC/CB-non-BIT: latch i_Result into o_Mem_Wdata, -> WRITE; else o_Done, -> IDLE.
//   WRITE: o_Mem_Req=1, We=1, Addr_Sel=0; on ack o_Done, -> IDLE.
//  Latency (i_Enable=1, ack immediate): reg op Done 1 cycle after Start; mem/imm read 2; (HL) RMW 3.
//  Wait counter: clears on state entry, increments per enabled cycle without ack in FETCH/WRITE; reaching MAX_WAIT
//   -> o_Error+o_Done, no writes, -> IDLE. Ack in the MAX_WAIT cycle wins over timeout.
//  i_Start while busy ignored (not queued). Done and next Start may coincide: Start accepted only if state is IDLE that cycle.
//  i_Enable low: state frozen, strobes (Save_Flags, writes, Done, Error) forced 0; Mem_Req holds.
// STRUCTURE
//  Shared header alu_ctrl_defs.vh: state encodings, FC bit positions, class codes, register index 6 = (HL).
//  Sub-module alu_op_decoder: combinational opcode+prefix -> class, FC bits, reg field, uses_mem, rmw, writes_A.
// TESTING
//  Reset mid-WRITE of INC (HL) -> next cycle IDLE, o_Mem_Req=0, no o_Done.
//  Start 0x80 (ADD A,B) -> next cycle FC=000001, Reg_Sel=0, ALU_Write=01, Save_Flags, Done; Busy 1 cycle.
//  Start 0xFE (CP n8), ack after 3 cycles with data 0x42 -> o_Operand=0x42, FC=000001, ALU_Write=00, Save_Flags, Done.
//  Start CB 0x06 (RLC (HL)), i_Result=0x81 -> read HL, EXEC FC=001000, WRITE Wdata=0x81 We=1, Done on ack.
//  Start 0x34 (INC (HL)), ack withheld, MAX_WAIT=15 -> o_Error+o_Done after 15 enabled cycles, no write request.
//  Start 0x07 (RLCA) with i_Enable toggling 1/0 -> FC=011000, strobes only in enabled cycle; 0xD3 -> o_Error pulse.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer_pkg: state, opcode class and ALU function-control definitions shared by the sequencer
package alu_op_sequencer_pkg;
    typedef enum logic [1:0] {IDLE, EXEC, FETCH, WRITE} state_e;
    typedef enum logic [3:0] {
        CLS_NONE, CLS_ALU, CLS_ALU_IMM, CLS_INC, CLS_DEC, CLS_ROT_A, CLS_MISC_A, CLS_CB, CLS_BIT
    } op_class_e;
    localparam logic [5:0] FC_MAIN  = 6'b000001;
    localparam logic [5:0] FC_INC   = 6'b000010;
    localparam logic [5:0] FC_DEC   = 6'b000100;
    localparam logic [5:0] FC_LOGIC = 6'b001000;
    localparam logic [5:0] FC_NO_Z  = 6'b010000;
    localparam logic [5:0] FC_MISC  = 6'b100000;
    localparam logic [2:0] REG_HL   = 3'd6;
    typedef struct packed {
        logic [5:0] fc;
        logic [2:0] sel;
        logic       mem;
        logic       imm;
        logic       rmw;
        logic       wr_a;
        logic       wr_reg;
    } dec_t;
    function automatic logic [5:0] fc_of(input op_class_e c);
        return c inside {CLS_ALU, CLS_ALU_IMM} ? FC_MAIN
             : c == CLS_INC ? FC_INC
             : c == CLS_DEC ? (FC_INC | FC_DEC)
             : c == CLS_ROT_A ? (FC_LOGIC | FC_NO_Z)
             : c == CLS_MISC_A ? FC_MISC
             : c inside {CLS_CB, CLS_BIT} ? FC_LOGIC
             : 6'b000000;
    endfunction
endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: memory port between the sequencer (master) and the memory unit (slave)
interface alu_op_sequencer_if;
    logic       req;
    logic       we;
    logic       addr_sel;
    logic       ack;
    logic [7:0] wdata;
    logic [7:0] rdata;
    modport master(output req, we, addr_sel, wdata, input ack, rdata);
    modport slave(input req, we, addr_sel, wdata, output ack, rdata);
endinterface

// File: rtl/alu_op_sequencer_decoder.sv
// alu_op_sequencer_decoder: classifies an opcode and derives its ALU controls, register field and memory needs
module alu_op_sequencer_decoder
    import alu_op_sequencer_pkg::*;
(
    input  logic [7:0] i_opcode,
    input  logic       i_prefix_cb,
    output logic       o_ok,
    output dec_t       o_dec
);
    op_class_e cls;
    logic [2:0] sel;
    logic       reg_class;
    always_comb begin
        cls = i_prefix_cb ? (i_opcode[7:6] == 2'b01 ? CLS_BIT : CLS_CB)
            : i_opcode[7:6] == 2'b10 ? CLS_ALU
            : (i_opcode[7:6] == 2'b11 && i_opcode[2:0] == 3'b110) ? CLS_ALU_IMM
            : (i_opcode[7:6] == 2'b00 && i_opcode[2:0] == 3'b100) ? CLS_INC
            : (i_opcode[7:6] == 2'b00 && i_opcode[2:0] == 3'b101) ? CLS_DEC
            : (i_opcode[7:5] == 3'b000 && i_opcode[2:0] == 3'b111) ? CLS_ROT_A
            : (i_opcode[7:5] == 3'b001 && i_opcode[2:0] == 3'b111) ? CLS_MISC_A
            : CLS_NONE;
        sel = cls inside {CLS_INC, CLS_DEC} ? i_opcode[5:3] : i_opcode[2:0];
        reg_class = cls inside {CLS_INC, CLS_DEC, CLS_CB};
        o_ok = cls != CLS_NONE;
        o_dec.fc = fc_of(cls);
        o_dec.sel = sel;
        o_dec.mem = o_ok && sel == REG_HL;
        o_dec.imm = cls == CLS_ALU_IMM;
        o_dec.rmw = reg_class && sel == REG_HL;
        o_dec.wr_a = (cls inside {CLS_ALU, CLS_ALU_IMM} && i_opcode[5:3] != 3'b111) || cls inside {CLS_ROT_A, CLS_MISC_A};
        o_dec.wr_reg = reg_class && sel != REG_HL;
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives ALU controls, operand fetch and (HL) write-back for one ALU-class instruction per start
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Enable,
    input  logic              i_Start,
    input  logic [7:0]        i_Opcode,
    input  logic              i_Prefix_CB,
    output logic              o_Busy,
    output logic              o_Done,
    output logic              o_Error,
    output logic [7:0]        o_Opcode,
    output logic [5:0]        o_Function_Control,
    output logic              o_Save_Flags,
    output logic [1:0]        o_ALU_Write,
    output logic [2:0]        o_Reg_Sel,
    output logic              o_Reg_Write,
    output logic              o_Param_Src,
    output logic [7:0]        o_Operand,
    input  logic [7:0]        i_Result,
    alu_op_sequencer_if.master mem
);
    localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    state_e        state_q, state_d;
    dec_t          dec, dec_q, dec_d;
    logic          dec_ok;
    logic [7:0]    opcode_q, opcode_d, operand_q, operand_d, wdata_q, wdata_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          err_q, err_d;
    logic          run, mem_phase, timeout, exec;
    alu_op_sequencer_decoder u_dec (
        .i_opcode(i_Opcode),
        .i_prefix_cb(i_Prefix_CB),
        .o_ok(dec_ok),
        .o_dec(dec)
    );
    assign run = i_Enable && !i_Reset;
    assign mem_phase = state_q == FETCH || state_q == WRITE;
    assign timeout = MAX_WAIT != 0 && mem_phase && !mem.ack && wait_q == WW'(MAX_WAIT - 1);
    assign exec = run && state_q == EXEC;
    always_comb begin
        state_d = state_q;
        dec_d = dec_q;
        opcode_d = opcode_q;
        operand_d = operand_q;
        wdata_d = wdata_q;
        wait_d = wait_q;
        err_d = err_q;
        if (i_Enable) begin
            err_d = 1'b0;
            wait_d = (MAX_WAIT != 0 && mem_phase && !mem.ack && !timeout) ? wait_q + WW'(1) : '0;
            case (state_q)
                IDLE: if (i_Start) begin
                    opcode_d = i_Opcode;
                    dec_d = dec;
                    err_d = !dec_ok;
                    state_d = !dec_ok ? IDLE : dec.mem ? FETCH : EXEC;
                end
                FETCH: if (mem.ack) begin
                    operand_d = mem.rdata;
                    state_d = EXEC;
                end else if (timeout) state_d = IDLE;
                EXEC: begin
                    wdata_d = dec_q.rmw ? i_Result : wdata_q;
                    state_d = dec_q.rmw ? WRITE : IDLE;
                end
                WRITE: state_d = (mem.ack || timeout) ? IDLE : WRITE;
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= IDLE;
            dec_q <= '0;
            opcode_q <= '0;
            operand_q <= '0;
            wdata_q <= '0;
            wait_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dec_q <= dec_d;
            opcode_q <= opcode_d;
            operand_q <= operand_d;
            wdata_q <= wdata_d;
            wait_q <= wait_d;
            err_q <= err_d;
        end
    end
    assign o_Busy = state_q != IDLE;
    assign o_Error = run && (err_q || timeout);
    assign o_Done = o_Error || (exec && !dec_q.rmw) || (run && state_q == WRITE && mem.ack);
    assign o_Opcode = opcode_q;
    assign o_Function_Control = state_q == EXEC ? dec_q.fc : 6'b000000;
    assign o_Save_Flags = exec;
    assign o_ALU_Write = {1'b0, exec && dec_q.wr_a};
    assign o_Reg_Sel = dec_q.sel;
    assign o_Reg_Write = exec && dec_q.wr_reg;
    assign o_Param_Src = state_q == EXEC && dec_q.mem;
    assign o_Operand = operand_q;
    assign mem.req = mem_phase && !i_Reset;
    assign mem.we = state_q == WRITE;
    assign mem.addr_sel = state_q == FETCH && dec_q.imm;
    assign mem.wdata = wdata_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and randomized checks of the ALU op sequencer against a spec-level model
module tb_alu_op_sequencer;
    logic clk = 1'b0, rst = 1'b1, en = 1'b1, start = 1'b0, cb = 1'b0;
    logic [7:0] opcode = 8'h00, result = 8'h00;
    logic busy, done, err, save, reg_wr, psrc;
    logic [7:0] opc_o, operand;
    logic [5:0] fc;
    logic [1:0] alu_wr;
    logic [2:0] reg_sel;
    int errors = 0, checks = 0;

    typedef struct packed {
        logic ok;
        logic [5:0] fc;
        logic [2:0] sel;
        logic rd, imm, rmw, wa, wr;
    } exp_t;

    alu_op_sequencer_if mif();

    alu_op_sequencer #(.MAX_WAIT(15)) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Enable(en), .i_Start(start), .i_Opcode(opcode), .i_Prefix_CB(cb),
        .o_Busy(busy), .o_Done(done), .o_Error(err), .o_Opcode(opc_o), .o_Function_Control(fc),
        .o_Save_Flags(save), .o_ALU_Write(alu_wr), .o_Reg_Sel(reg_sel), .o_Reg_Write(reg_wr),
        .o_Param_Src(psrc), .o_Operand(operand), .i_Result(result), .mem(mif)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] pk(input logic b, input logic d, input logic e, input logic [5:0] f,
                                       input logic s, input logic [1:0] a, input logic [2:0] r, input logic w,
                                       input logic p, input logic q, input logic we, input logic as);
        return {b, d, e, f, s, a, r, w, p, q, we, as};
    endfunction

    function automatic logic [19:0] obs();
        return {busy, done, err, fc, save, alu_wr, reg_sel, reg_wr, psrc, mif.req, mif.we, mif.addr_sel};
    endfunction

    function automatic exp_t model(input logic [7:0] opb, input logic c);
        int o = int'(opb);
        int hi = o / 64;
        int mid = (o / 8) % 8;
        int lo = o % 8;
        exp_t e = '0;
        e.sel = 3'(lo);
        if (c) begin
            e.ok = 1'b1; e.fc = 6'h08;
            if (hi != 1) begin
                if (lo == 6) e.rmw = 1'b1; else e.wr = 1'b1;
            end
        end else if (hi == 2) begin
            e.ok = 1'b1; e.fc = 6'h01; e.wa = (mid != 7);
        end else if (hi == 3 && lo == 6) begin
            e.ok = 1'b1; e.fc = 6'h01; e.wa = (mid != 7); e.imm = 1'b1;
        end else if (hi == 0 && (lo == 4 || lo == 5)) begin
            e.ok = 1'b1; e.fc = (lo == 4) ? 6'h02 : 6'h06; e.sel = 3'(mid);
            if (mid == 6) e.rmw = 1'b1; else e.wr = 1'b1;
        end else if (hi == 0 && lo == 7) begin
            e.ok = 1'b1; e.fc = (mid < 4) ? 6'h18 : 6'h20; e.wa = 1'b1;
        end
        e.rd = e.ok && e.sel == 3'd6;
        return e;
    endfunction

    task automatic test_reset();
        logic [19:0] x;
        #2 checks++; if ({obs(), opc_o, operand, mif.wdata} !== 44'h0) begin errors++; $display("FAIL reset_state got=%h exp=0", {obs(), opc_o, operand, mif.wdata}); end
        rst = 1'b0; opcode = 8'h34; cb = 1'b0; start = 1'b1;
        cyc(); start = 1'b0; mif.ack = 1'b1; mif.rdata = 8'h10;
        #2 x = pk(1,0,0,6'h00,0,2'b00,3'd6,0,0,1,0,0); checks++; if (obs() !== x) begin errors++; $display("FAIL rst_fetch got=%h exp=%h", obs(), x); end
        cyc(); mif.ack = 1'b0; result = 8'h11;
        #2 x = pk(1,0,0,6'h02,1,2'b00,3'd6,0,1,0,0,0); checks++; if (obs() !== x) begin errors++; $display("FAIL rst_exec got=%h exp=%h", obs(), x); end
        cyc();
        #2 x = pk(1,0,0,6'h00,0,2'b00,3'd6,0,0,1,1,0); checks++; if (obs() !== x || mif.wdata !== 8'h11) begin errors++; $display("FAIL rst_write got=%h/%h exp=%h/11", obs(), mif.wdata, x); end
        rst = 1'b1; mif.ack = 1'b1;
        #1 checks++; if ({done, err, save, reg_wr, alu_wr} !== 6'h0) begin errors++; $display("FAIL rst_strobes got=%h exp=0", {done, err, save, reg_wr, alu_wr}); end
        cyc(); rst = 1'b0; mif.ack = 1'b0;
        #2 checks++; if (obs() !== 20'h0) begin errors++; $display("FAIL rst_idle got=%h exp=0", obs()); end
    endtask

    task automatic test_reg_op();
        logic [19:0] x;
        opcode = 8'h80; cb = 1'b0; start = 1'b1;
        #2 x = pk(0,0,0,6'h00,0,2'b00,3'd0,0,0,0,0,0); checks++; if (obs() !== x) begin errors++; $display("FAIL add_idle got=%h exp=%h", obs(), x); end
        cyc(); start = 1'b0;
        #2 x = pk(1,1,0,6'h01,1,2'b01,3'd0,0,0,0,0,0); checks++; if (obs() !== x) begin errors++; $display("FAIL add_exec got=%h exp=%h", obs(), x); end
        checks++; if (opc_o !== 8'h80) begin errors++; $display("FAIL add_opcode got=%h exp=80", opc_o); end
        cyc();
        #2 x = pk(0,0,0,6'h00,0,2'b00,3'd0,0,0,0,0,0); checks++; if (obs() !== x) begin errors++; $display("FAIL add_after got=%h exp=%h", obs(), x); end
    endtask

    task automatic test_imm();
        logic [19:0] x;
        opcode = 8'hFE; cb = 1'b0; start = 1'b1;
        cyc(); start = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            mif.ack = (k == 3); mif.rdata = (k == 3) ? 8'h42 : 8'h00;
            #2 x = pk(1,0,0,6'h00,0,2'b00,3'd6,0,0,1,0,1); checks++; if (obs() !== x) begin errors++; $display("FAIL cp_fetch%0d got=%h exp=%h", k, obs(), x); end
            cyc();
        end
        mif.ack = 1'b0;
        #2 x = pk(1,1,0,6'h01,1,2'b00,3'd6,0,1,0,0,0); checks++; if (obs() !== x) begin errors++; $display("FAIL cp_exec got=%h exp=%h", obs(), x); end
        checks++; if (operand !== 8'h42) begin errors++; $display("FAIL cp_operand got=%h exp=42", operand); end
        cyc();
        #2 checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cp_busy got=%b exp=0", busy); end
    endtask

    task automatic test_cb_rmw();
        logic [19:0] x;
        opcode = 8'h06; cb = 1'b1; start = 1'b1;
        cyc(); start = 1'b0; cb = 1'b0; mif.ack = 1'b1; mif.rdata = 8'h7E;
        #2 x = pk(1,0,0,6'h00,0,2'b00,3'd6,0,0,1,0,0); checks++; if (obs() !== x) begin errors++; $display("FAIL rlc_fetch got=%h exp=%h", obs(), x); end
        cyc(); mif.ack = 1'b0; result = 8'h81;
        #2 x = pk(1,0,0,6'h08,1,2'b00,3'd6,0,1,0,0,0); checks++; if (obs() !== x) begin errors++; $display("FAIL rlc_exec got=%h exp=%h", obs(), x); end
        cyc(); result = 8'h00;
        #2 x = pk(1,0,0,6'h00,0,2'b00,3'd6,0,0,1,1,0); checks++; if (obs() !== x || mif.wdata !== 8'h81) begin errors++; $display("FAIL rlc_write got=%h/%h exp=%h/81", obs(), mif.wdata, x); end
        cyc(); mif.ack = 1'b1;
        #2 x = pk(1,1,0,6'h00,0,2'b00,3'd6,0,0,1,1,0); checks++; if (obs() !== x) begin errors++; $display("FAIL rlc_ack got=%h exp=%h", obs(), x); end
        cyc(); mif.ack = 1'b0;
        #2 x = pk(0,0,0,6'h00,0,2'b00,3'd6,0,0,0,0,0); checks++; if (obs() !== x) begin errors++; $display("FAIL rlc_idle got=%h exp=%h", obs(), x); end
    endtask

    task automatic test_timeout();
        logic [19:0] x;
        int k = 0, cycles = 0;
        opcode = 8'h34; cb = 1'b0; start = 1'b1;
        cyc(); start = 1'b0;
        while (k < 15 && cycles < 100) begin
            en = 1'($urandom) | (cycles > 60);
            #2 x = pk(1, en && k == 14, en && k == 14, 6'h00,0,2'b00,3'd6,0,0,1,0,0); checks++; if (obs() !== x) begin errors++; $display("FAIL to_wait%0d got=%h exp=%h", cycles, obs(), x); end
            if (en) k++;
            cycles++;
            cyc();
        end
        en = 1'b1;
        checks++; if (k != 15) begin errors++; $display("FAIL to_budget got=%0d exp=15", k); end
        #2 x = pk(0,0,0,6'h00,0,2'b00,3'd6,0,0,0,0,0); checks++; if (obs() !== x) begin errors++; $display("FAIL to_idle got=%h exp=%h", obs(), x); end
        opcode = 8'h86; start = 1'b1;
        cyc(); start = 1'b0;
        for (int j = 0; j < 15; j++) begin
            mif.ack = (j == 14); mif.rdata = 8'h5A;
            #2 x = pk(1,0,0,6'h00,0,2'b00,3'd6,0,0,1,0,0); checks++; if (obs() !== x) begin errors++; $display("FAIL late_ack%0d got=%h exp=%h", j, obs(), x); end
            cyc();
        end
        mif.ack = 1'b0;
        #2 x = pk(1,1,0,6'h01,1,2'b01,3'd6,0,1,0,0,0); checks++; if (obs() !== x || operand !== 8'h5A) begin errors++; $display("FAIL late_exec got=%h/%h exp=%h/5a", obs(), operand, x); end
        cyc();
    endtask

    task automatic test_enable();
        logic [19:0] x;
        opcode = 8'h07; cb = 1'b0; start = 1'b1;
        cyc(); start = 1'b0; en = 1'b0;
        #2 x = pk(1,0,0,6'h18,0,2'b00,3'd7,0,0,0,0,0); checks++; if (obs() !== x) begin errors++; $display("FAIL rlca_frozen got=%h exp=%h", obs(), x); end
        cyc();
        #2 checks++; if (obs() !== x) begin errors++; $display("FAIL rlca_frozen2 got=%h exp=%h", obs(), x); end
        cyc(); en = 1'b1;
        #2 x = pk(1,1,0,6'h18,1,2'b01,3'd7,0,0,0,0,0); checks++; if (obs() !== x) begin errors++; $display("FAIL rlca_exec got=%h exp=%h", obs(), x); end
        cyc(); en = 1'b0; opcode = 8'h80; start = 1'b1;
        cyc(); en = 1'b1; start = 1'b0;
        #2 x = pk(0,0,0,6'h00,0,2'b00,3'd7,0,0,0,0,0); checks++; if (obs() !== x) begin errors++; $display("FAIL start_disabled got=%h exp=%h", obs(), x); end
    endtask

    task automatic test_unsupported();
        logic [19:0] x;
        opcode = 8'hD3; cb = 1'b0; start = 1'b1;
        cyc(); start = 1'b0;
        #2 x = pk(0,1,1,6'h00,0,2'b00,3'd3,0,0,0,0,0); checks++; if (obs() !== x || opc_o !== 8'hD3) begin errors++; $display("FAIL bad_op got=%h/%h exp=%h/d3", obs(), opc_o, x); end
        cyc();
        #2 x = pk(0,0,0,6'h00,0,2'b00,3'd3,0,0,0,0,0); checks++; if (obs() !== x) begin errors++; $display("FAIL bad_op_after got=%h exp=%h", obs(), x); end
    endtask

    task automatic test_random();
        logic [19:0] x;
        logic [7:0] op, data, res;
        logic [2:0] prev;
        exp_t e;
        int d;
        prev = 3'd3;
        for (int n = 0; n < 80; n++) begin
            op = 8'($urandom); cb = ($urandom_range(3) == 0); e = model(op, cb);
            opcode = op; start = 1'b1;
            #2 x = pk(0,0,0,6'h00,0,2'b00,prev,0,0,0,0,0); checks++; if (obs() !== x) begin errors++; $display("FAIL rnd%0d_idle got=%h exp=%h", n, obs(), x); end
            cyc();
            start = e.ok ? 1'($urandom) : 1'b0; opcode = 8'($urandom); cb = 1'($urandom);
            if (!e.ok) begin
                #2 x = pk(0,1,1,6'h00,0,2'b00,e.sel,0,0,0,0,0); checks++; if (obs() !== x) begin errors++; $display("FAIL rnd%0d_bad got=%h exp=%h", n, obs(), x); end
                cyc();
            end else begin
                data = 8'($urandom);
                if (e.rd) begin
                    d = $urandom_range(3);
                    for (int k = 0; k <= d; k++) begin
                        mif.ack = (k == d); mif.rdata = (k == d) ? data : 8'($urandom);
                        #2 x = pk(1,0,0,6'h00,0,2'b00,e.sel,0,0,1,0,e.imm); checks++; if (obs() !== x) begin errors++; $display("FAIL rnd%0d_fetch got=%h exp=%h", n, obs(), x); end
                        cyc();
                    end
                    mif.ack = 1'b0;
                end
                res = 8'($urandom); result = res;
                #2 x = pk(1,!e.rmw,0,e.fc,1,{1'b0,e.wa},e.sel,e.wr,e.rd,0,0,0); checks++; if (obs() !== x || opc_o !== op || (e.rd && operand !== data)) begin errors++; $display("FAIL rnd%0d_exec op=%h cb=%b got=%h/%h exp=%h/%h", n, op, e.fc == 6'h08, obs(), opc_o, x, op); end
                cyc();
                if (e.rmw) begin
                    d = $urandom_range(3);
                    for (int k = 0; k <= d; k++) begin
                        mif.ack = (k == d); result = 8'($urandom);
                        #2 x = pk(1,k == d,0,6'h00,0,2'b00,e.sel,0,0,1,1,0); checks++; if (obs() !== x || mif.wdata !== res) begin errors++; $display("FAIL rnd%0d_write got=%h/%h exp=%h/%h", n, obs(), mif.wdata, x, res); end
                        cyc();
                    end
                    mif.ack = 1'b0;
                end
            end
            prev = e.sel;
        end
        start = 1'b0;
    endtask

    initial begin
        mif.ack = 1'b0;
        mif.rdata = 8'h00;
        cyc();
        cyc();
        test_reset();
        test_reg_op();
        test_imm();
        test_cb_rmw();
        test_timeout();
        test_enable();
        test_unsupported();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
